// File: rtl/alu_cmd_sender.sv
// rtl/alu_cmd_sender.sv - serialises A, B, OP over a tx_uart and waits for the rx_uart result byte
module alu_cmd_sender #(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int TIMEOUT  = 1000000,
    parameter int NB_TIMER = 20
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation,
    output logic               o_busy,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done_tick,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic               o_timeout
);

    localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_TX = 2'd2,
        WAIT_RX = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_idx;
    logic [NB_TIMER-1:0]  r_timer;
    logic [NB_DATA-1:0]   r_b;
    logic [NB_DATA-1:0]   r_op;
    logic                 r_tx_start;
    logic [NB_DATA-1:0]   r_tx_data;
    logic [NB_DATA-1:0]   r_result;
    logic                 r_result_valid;
    logic                 r_timeout;
    logic [NB_DATA-1:0]   w_op_ext;

    assign w_op_ext = NB_DATA'(i_operation);

    // Byte A goes straight into the tx register, so only B and OP need latching;
    // the next byte is loaded together with the start pulse so both line up with LOAD.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= IDLE;
            r_idx          <= 2'd0;
            r_timer        <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_tx_start     <= 1'b0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_b        <= i_data_b;
                        r_op       <= w_op_ext;
                        r_tx_data  <= i_data_a;
                        r_tx_start <= 1'b1;
                        r_idx      <= 2'd0;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done_tick) begin
                        if (r_idx == 2'd2) begin
                            r_timer <= '0;
                            r_state <= WAIT_RX;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_tx_data  <= (r_idx == 2'd0) ? r_b : r_op;
                            r_tx_start <= 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                end
                WAIT_RX: begin
                    // A result arriving on the expiry cycle still counts as a result.
                    if (i_rx_done_tick) begin
                        r_result       <= i_rx_data;
                        r_result_valid <= 1'b1;
                        r_state        <= IDLE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy         = (r_state != IDLE);
    assign o_tx_start     = r_tx_start;
    assign o_tx_data      = r_tx_data;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_timeout      = r_timeout;

endmodule
